// File: rtl/vec_check_pkg.sv
// vec_check_pkg: shared lane count, error-counter width, checker states and lane-select helper.
package vec_check_pkg;
    localparam int LANES = 4;
    localparam int ERR_W = 16;

    typedef enum logic [1:0] {S_WARMUP, S_CHECK, S_DONE} check_state_t;

    // Lowest set bit index of a per-lane miscompare mask.
    function automatic logic [1:0] low_lane(input logic [LANES-1:0] m);
        logic [1:0] l;
        l = 2'd0;
        for (int i = LANES - 1; i >= 0; i--)
            if (m[i]) l = 2'(i);
        return l;
    endfunction
endpackage

// File: rtl/vec_delay.sv
// vec_delay: LATENCY-stage shift register for {valid, 4 expected lanes}; only the valid bits are cleared.
module vec_delay
    import vec_check_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] out_data
);
    localparam int DW = LANES * WIDTH;

    logic [LATENCY-1:0]    v_q, v_d;
    logic [LATENCY*DW-1:0] d_q, d_d;

    // Truncating casts drop the oldest stage and also cover LATENCY == 1.
    always_comb begin
        v_d = LATENCY'({v_q, in_valid});
        d_d = (LATENCY*DW)'({d_q, in_data});
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) v_q <= '0;
        else        v_q <= v_d;

    always_ff @(posedge clock)
        d_q <= d_d;

    assign out_valid = v_q[LATENCY-1];
    assign out_data  = d_q[LATENCY*DW-1 -: DW];
endmodule

// File: rtl/vec_add_checker.sv
// vec_add_checker: recomputes 4-lane sums, aligns them to the pipeline latency and
// compares them against the pipeline outputs after a warm-up window, reporting registered statistics.
module vec_add_checker
    import vec_check_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int LATENCY   = 2,
    parameter int WARMUP    = 5000,
    parameter int CHECK_LEN = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] a_0,
    input  logic [WIDTH-1:0] a_1,
    input  logic [WIDTH-1:0] a_2,
    input  logic [WIDTH-1:0] a_3,
    input  logic [WIDTH-1:0] b_0,
    input  logic [WIDTH-1:0] b_1,
    input  logic [WIDTH-1:0] b_2,
    input  logic [WIDTH-1:0] b_3,
    input  logic [WIDTH-1:0] y_0,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    input  logic [WIDTH-1:0] y_3,
    output logic             mismatch,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       first_err_lane,
    output logic [31:0]      first_err_cycle,
    output logic             done,
    output logic             pass
);
    logic [LANES-1:0][WIDTH-1:0] a, b, y, e, de;
    logic [LANES-1:0]            diff;
    logic                        dv, cmp, fail, last, first;

    check_state_t     state_q, state_d;
    logic [31:0]      cyc_q, cyc_d, nchk_q, nchk_d, fcyc_q, fcyc_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [1:0]       lane_q, lane_d;
    logic             mismatch_q, mismatch_d, done_q, done_d, pass_q, pass_d;

    assign a = {a_3, a_2, a_1, a_0};
    assign b = {b_3, b_2, b_1, b_0};
    assign y = {y_3, y_2, y_1, y_0};

    always_comb begin
        e = '0;
        for (int i = 0; i < LANES; i++) e[i] = a[i] + b[i];
    end

    vec_delay #(.WIDTH(WIDTH), .LATENCY(LATENCY)) u_delay (
        .clock    (clock),
        .reset    (reset),
        .in_valid (en),
        .in_data  (e),
        .out_valid(dv),
        .out_data (de)
    );

    always_comb begin
        diff = '0;
        for (int i = 0; i < LANES; i++) diff[i] = y[i] != de[i];
        cmp        = state_q == S_CHECK && dv;
        fail       = cmp && |diff;
        last       = cmp && nchk_q == 32'(CHECK_LEN - 1);
        first      = fail && err_q == '0;
        cyc_d      = &cyc_q ? cyc_q : cyc_q + 32'd1;
        nchk_d     = cmp ? nchk_q + 32'd1 : nchk_q;
        err_d      = fail && !(&err_q) ? err_q + 1'b1 : err_q;
        lane_d     = first ? low_lane(diff) : lane_q;
        fcyc_d     = first ? cyc_q : fcyc_q;
        mismatch_d = fail;
        done_d     = done_q || last;
        pass_d     = done_d && err_d == '0;
        state_d    = state_q;
        case (state_q)
            S_WARMUP: state_d = cyc_q == 32'(WARMUP - 1) ? S_CHECK : S_WARMUP;
            S_CHECK:  state_d = last ? S_DONE : S_CHECK;
            default:  state_d = S_DONE;
        endcase
    end

    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state_q    <= S_WARMUP;
            cyc_q      <= '0;
            nchk_q     <= '0;
            err_q      <= '0;
            lane_q     <= '0;
            fcyc_q     <= '0;
            mismatch_q <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cyc_q      <= cyc_d;
            nchk_q     <= nchk_d;
            err_q      <= err_d;
            lane_q     <= lane_d;
            fcyc_q     <= fcyc_d;
            mismatch_q <= mismatch_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end

    assign mismatch        = mismatch_q;
    assign err_count       = err_q;
    assign first_err_lane  = lane_q;
    assign first_err_cycle = fcyc_q;
    assign done            = done_q;
    assign pass            = pass_q;
endmodule

// File: doc/vec_add_checker.md
# vec_add_checker

Synthesizable self-checking monitor for the 4-lane vector-add pipeline. It consumes the operand vectors and enable driven into the pipeline, recomputes the expected sums and delays them to match pipeline latency. It then compares them against the pipeline outputs once the post-reset warm-up window has elapsed. The block sits beside the `main` DUT in the regression harness and reports pass/fail and error statistics as registered outputs, so a result is available in silicon or in simulation without `$display` scraping.

## Interface
- `WIDTH`, 8, lane data width in bits
- `LATENCY`, 2, DUT pipeline depth in cycles from operand/`en` to `y_*`; legal range 1..16
- `WARMUP`, 5000, cycles after reset release before checking starts (covers GSR init); must be ≥ 1
- `CHECK_LEN`, 4, number of valid samples to compare before declaring done; must be ≥ 1

- `clock` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset (asserted when 0)
- `en` in 1: enable presented to the DUT together with the operands
- `a_0`..`a_3` in WIDTH: operand A lanes as presented to the DUT
- `b_0`..`b_3` in WIDTH: operand B lanes as presented to the DUT
- `y_0`..`y_3` in WIDTH: DUT result lanes
- `mismatch` out 1: one-cycle pulse; at least one lane miscompared on the previous cycle
- `err_count` out 16: count of miscompared samples, saturating at 16'hFFFF
- `first_err_lane` out 2: lowest miscomparing lane index of the first failing sample
- `first_err_cycle` out 32: cycle-counter value of the first failing sample
- `done` out 1: CHECK_LEN samples compared; sticky until reset
- `pass` out 1: `done` and `err_count == 0`

## Operation
- Expected value: `e_i = (a_i + b_i) mod 2^WIDTH`, i.e. the carry is dropped. For example, 0 + (-2) gives 8'hFE.
- Delay line: {`en`, e_0..e_3} are shifted through a LATENCY-stage register. The delayed valid is `dv` and the delayed expectations are `de_i`. Valid bits clear on reset. The line runs in every state, so it is already filled when checking starts.
- Cycle counter `cyc`: 32 bits, 0 in reset, +1 on every edge, saturating at all-ones.
- FSM states:
  - WARMUP → CHECK on the edge where `cyc == WARMUP-1`.
  - CHECK → DONE on the edge where a compared sample brings `nchk` to CHECK_LEN.
  - DONE holds until reset.
- Compare happens only in CHECK with `dv == 1`. A sample fails if any `y_i != de_i`. `nchk` counts compared samples, passing and failing alike.
- On a failing sample:
  - `err_count` increments unless it is saturated.
  - `mismatch` is 1 on the next cycle.
  - If this is the first failure, capture `first_err_lane` and `first_err_cycle = cyc`.
- Samples with `dv == 0` are neither compared nor counted.
- In WARMUP and DONE, `y_*` mismatches are ignored.

## Timing
- Reset values: `mismatch` 0, `err_count` 0, `first_err_lane` 0, `first_err_cycle` 0, `done` 0, `pass` 0. State resets to WARMUP, `cyc` 0, `nchk` 0.
- All outputs are registered. A sample compared in cycle t is reflected in `mismatch`/`err_count`/`first_err_*` at t+1.
- `done`/`pass` rise at t+1 after the CHECK_LEN-th compare.
- The first compare cycle is `cyc == WARMUP`. `y_*` at that cycle is paired with operands applied at `cyc == WARMUP-LATENCY`.
- Last compare and a failure in the same cycle: the failure is counted, and `pass` stays 0.
- Reset asserted mid-CHECK: all state clears immediately (asynchronous), and the block restarts in WARMUP after release.

## Structure
- Package `vec_check_pkg`:
  - `LANES = 4`
  - state enum `check_state_t` {WARMUP, CHECK, DONE}
  - `ERR_W = 16`
- Sub-module `vec_delay`: a parameterized LATENCY-stage shift register carrying the valid bit plus 4×WIDTH expected values. It has async active-low clear on the valid bits only.
- Top module: sum computation, counter, FSM, comparator, capture registers.

## Test plan
Bench settings: WARMUP=8, LATENCY=2, CHECK_LEN=4. Operands a = 0,3,2,1 and b = -2,2,4,8, so expected y = -2,5,6,9.
- Ideal DUT model (2-cycle delayed correct sums), `en` = 1 → `done` = 1 at cyc 12, `pass` = 1, `err_count` = 0, `mismatch` never 1.
- Model corrupts y_2 to 7 for the sample compared at cyc 10 → `mismatch` = 1 at cyc 11, `err_count` = 1, `first_err_lane` = 2, `first_err_cycle` = 10, `done` = 1 with `pass` = 0.
- Wrong outputs only during warm-up (cyc < 8), correct thereafter → `pass` = 1, `err_count` = 0.
- `en` = 0 for two cycles in the middle → those samples are skipped. `done` is delayed by 2 cycles to cyc 14, `pass` = 1.
- Overflow: a_3 = 8'hFF, b_3 = 8'h02, DUT returns 8'h01 → no mismatch (wraparound is expected behaviour).
- Reset driven low at cyc 10 for 2 cycles after an injected error → all outputs return to 0 immediately. After release, a full WARMUP/CHECK sequence completes with `pass` = 1.
